// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus optional iterative shift-add multiply, registered with valid/ready.
// Define EXECUTE_MUL_EN to build the multi-cycle multiply for ALUop 110; otherwise 110 yields zero in one cycle.
module execute_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUop_in,
  input  logic [WIDTH-1:0] srcA_in,
  input  logic [WIDTH-1:0] srcB_in,
  input  logic             wbs_in,
  input  logic             wme_in,
  input  logic             mm_in,
  input  logic             wm_in,
  input  logic             am_in,
  input  logic             ni_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_out,
  output logic             zero_out,
  output logic             neg_out,
  output logic             carry_out,
  output logic             wbs_out,
  output logic             wme_out,
  output logic             mm_out,
  output logic             wm_out,
  output logic             am_out,
  output logic             ni_out
);
  localparam int CW = $clog2(WIDTH);

  logic [5:0]       ctrl_in, ctrl_q;
  logic [WIDTH:0]   sum, diff, shl_w;
  logic [3:0]       shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             idle, accept, is_mul;

  assign ctrl_in = {wbs_in, wme_in, mm_in, wm_in, am_in, ni_in};
  assign {wbs_out, wme_out, mm_out, wm_out, am_out, ni_out} = ctrl_q;

  // Extra top bit carries out of add, borrow out of sub, and the last bit shifted out of shl.
  assign shamt = srcB_in[3:0];
  assign sum   = {1'b0, srcA_in} + {1'b0, srcB_in};
  assign diff  = {1'b0, srcA_in} - {1'b0, srcB_in};
  assign shl_w = {1'b0, srcA_in} << shamt;

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (ALUop_in)
      3'b000: begin alu_res = sum[WIDTH-1:0];   alu_carry = sum[WIDTH];   end
      3'b001: begin alu_res = diff[WIDTH-1:0];  alu_carry = diff[WIDTH];  end
      3'b010: alu_res = srcA_in & srcB_in;
      3'b011: alu_res = srcA_in | srcB_in;
      3'b100: alu_res = srcA_in ^ srcB_in;
      3'b101: begin alu_res = shl_w[WIDTH-1:0]; alu_carry = shl_w[WIDTH]; end
      3'b111: alu_res = srcA_in >> shamt;
      default: alu_res = '0;
    endcase
  end

`ifdef EXECUTE_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;
  state_t           state, state_nxt;
  logic [WIDTH-1:0] mul_a, mul_b, acc, acc_nxt;
  logic [5:0]       mul_ctrl;
  logic [CW-1:0]    cnt;
  logic             last_iter, mul_done;

  assign is_mul    = (ALUop_in == 3'b110);
  assign idle      = (state == IDLE);
  assign last_iter = (cnt == CW'(WIDTH - 1));
  assign mul_done  = (state == MUL) && last_iter;
  assign acc_nxt   = acc + (mul_b[cnt] ? (mul_a << cnt) : '0);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_mul) state_nxt = MUL;
      MUL:     if (flush || last_iter) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a    <= '0;
      mul_b    <= '0;
      mul_ctrl <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else if (state == IDLE) begin
      if (accept && is_mul) begin
        mul_a    <= srcA_in;
        mul_b    <= srcB_in;
        mul_ctrl <= ctrl_in;
        acc      <= '0;
        cnt      <= '0;
      end
    end else if (flush || last_iter) begin
      cnt <= '0;
    end else begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
    end
  end
`else
  assign is_mul = 1'b0;
  assign idle   = 1'b1;
`endif

  assign in_ready = rst_n && idle && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // Flush outranks both a new load and multiply completion; data outputs only move on a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      result_out <= '0;
      zero_out   <= 1'b0;
      neg_out    <= 1'b0;
      carry_out  <= 1'b0;
      ctrl_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
`ifdef EXECUTE_MUL_EN
    end else if (mul_done) begin
      out_valid  <= 1'b1;
      result_out <= acc_nxt;
      zero_out   <= (acc_nxt == '0);
      neg_out    <= acc_nxt[WIDTH-1];
      carry_out  <= 1'b0;
      ctrl_q     <= mul_ctrl;
`endif
    end else if (accept && !is_mul) begin
      out_valid  <= 1'b1;
      result_out <= alu_res;
      zero_out   <= (alu_res == '0);
      neg_out    <= alu_res[WIDTH-1];
      carry_out  <= alu_carry;
      ctrl_q     <= ctrl_in;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
